// File: rtl/mdu_sequencer_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
// The master issues ops and reads HI/LO; the slave is the sequencer itself.
interface mdu_sequencer_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op_valid, op, src_a, src_b, cancel,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b, cancel,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one product/quotient bit
// per cycle, then a single sign-fixup cycle that commits the result.
module mdu_sequencer #(
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    mdu_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    // Magnitude of an operand; 33-bit negate so that abs(0x80000000) stays exact.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        logic [32:0] ext;
        logic [32:0] neg;
        ext = {1'b1, v};
        neg = ~ext + 33'd1;
        if (is_signed && v[31]) begin
            return neg[31:0];
        end else begin
            return v;
        end
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;        // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd_r;       // multiplicand or divisor magnitude
    logic [31:0] raw_a_r;
    logic        is_div_r;
    logic        div_zero_r;
    logic        quo_neg_r;
    logic        rem_neg_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;

    logic        accept_s;
    logic        op_signed_s;
    logic        op_div_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        start_s;
    logic        calc_en_s;
    logic        fix_en_s;
    logic        mthi_s;
    logic        mtlo_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_hi_s;
    logic [31:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] div_step_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    assign accept_s    = (state_r == IDLE) && bus.op_valid && !bus.cancel;
    assign op_signed_s = ~bus.op[0];
    assign op_div_s    = bus.op[1];
    assign mag_a_s     = magnitude(bus.src_a, op_signed_s);
    assign mag_b_s     = magnitude(bus.src_b, op_signed_s);

    assign bus.busy  = (state_r != IDLE);
    assign bus.stall = (state_r != IDLE) || (bus.op_valid && !bus.op[2] && (state_r == IDLE));
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_next_s = {mul_sum_s, acc_r[31:1]};
        div_hi_s   = acc_r[63:31];
        div_diff_s = div_hi_s[31:0] - opnd_r;
        if (div_hi_s >= {1'b0, opnd_r}) begin
            div_next_s = {div_diff_s, acc_r[30:0], 1'b1};
        end else begin
            div_next_s = {acc_r[62:0], 1'b0};
        end
        if (is_div_r) begin
            div_step_s = div_next_s;
        end else begin
            div_step_s = mul_next_s;
        end
    end

    // Sign correction and divide-by-zero override for the commit cycle.
    always_comb begin
        prod_s   = quo_neg_r ? (~acc_r + 64'd1) : acc_r;
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
        if (is_div_r) begin
            if (div_zero_r) begin
                res_hi_s = raw_a_r;
                res_lo_s = 32'hFFFF_FFFF;
            end else begin
                res_lo_s = quo_neg_r ? (~acc_r[31:0] + 32'd1) : acc_r[31:0];
                res_hi_s = rem_neg_r ? (~acc_r[63:32] + 32'd1) : acc_r[63:32];
            end
        end else begin
            res_hi_s = prod_s[63:32];
        end
    end

    // Next-state and per-cycle enables.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        calc_en_s    = 1'b0;
        fix_en_s     = 1'b0;
        mthi_s       = 1'b0;
        mtlo_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (!bus.op[2]) begin
                        start_s      = 1'b1;
                        state_next_s = CALC;
                    end else if (bus.op == 3'd4) begin
                        mthi_s = 1'b1;
                    end else if (bus.op == 3'd5) begin
                        mtlo_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_next_s = IDLE;
                end else begin
                    calc_en_s = 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        state_next_s = FIX;
                    end else begin
                        state_next_s = CALC;
                    end
                end
            end
            FIX: begin
                state_next_s = IDLE;
                if (!bus.cancel) begin
                    fix_en_s = 1'b1;
                end else begin
                    fix_en_s = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch, iteration datapath and HI/LO commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 5'd0;
            acc_r      <= 64'd0;
            opnd_r     <= 32'd0;
            raw_a_r    <= 32'd0;
            is_div_r   <= 1'b0;
            div_zero_r <= 1'b0;
            quo_neg_r  <= 1'b0;
            rem_neg_r  <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            done_r     <= 1'b0;
        end else begin
            if (start_s) begin
                cnt_r      <= 5'd0;
                acc_r      <= {32'd0, (op_div_s ? mag_a_s : mag_b_s)};
                opnd_r     <= op_div_s ? mag_b_s : mag_a_s;
                raw_a_r    <= bus.src_a;
                is_div_r   <= op_div_s;
                div_zero_r <= op_div_s && (bus.src_b == 32'd0);
                quo_neg_r  <= op_signed_s && (bus.src_a[31] ^ bus.src_b[31]);
                rem_neg_r  <= op_signed_s && bus.src_a[31];
            end else if (calc_en_s) begin
                acc_r <= div_step_s;
                cnt_r <= cnt_r + 5'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (fix_en_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else if (mthi_s) begin
                hi_r <= bus.src_a;
            end else if (mtlo_s) begin
                lo_r <= bus.src_a;
            end else begin
                hi_r <= hi_r;
            end
            done_r <= fix_en_s;
        end
    end
endmodule
